// File: rtl/ysyx_23060236_axi_sram_slave.sv
// AXI4 subordinate backed by a word-addressed on-chip SRAM.
// Reads: single-beat and FIXED/INCR/WRAP bursts with per-beat OKAY/SLVERR/DECERR.
// Writes: single-beat, byte-masked; longer AW bursts are drained and answered SLVERR.
// Ports:
//   clock, reset (async, active-low)
//   AW: awready/awvalid/awaddr/awid/awlen/awsize/awburst
//   W : wready/wvalid/wdata/wstrb/wlast
//   B : bready/bvalid/bresp/bid
//   AR: arready/arvalid/araddr/arid/arlen/arsize/arburst
//   R : rready/rvalid/rresp/rdata/rlast/rid
module ysyx_23060236_axi_sram_slave #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_e;

  logic [31:0] r_mem [2**ADDR_W];

  // ---------------- read side ----------------
  r_state_e    r_rstate;
  logic [31:0] r_addr;
  logic [7:0]  r_len, r_beat, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_id;
  logic        r_arready, r_rvalid, r_rlast;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [3:0]  r_rid;

  logic [31:0] w_incr, w_wrap_mask, w_addr_inc, w_next_addr, w_beat_addr, w_beat_data;
  logic [1:0]  w_beat_resp;
  logic        w_cfg_err;

  assign w_incr      = 32'd1 << r_size;
  // WRAP boundary is (len+1) beats of 2^size bytes; only meaningful when the config is legal.
  assign w_wrap_mask = ((32'(r_len) + 32'd1) << r_size) - 32'd1;
  assign w_cfg_err   = (r_burst == 2'b11) || (r_size > 3'd2) || (r_len[7:4] != 4'd0) ||
                       ((r_burst == BURST_WRAP) && !(r_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

  always_comb begin
    w_addr_inc  = r_addr + w_incr;
    w_next_addr = r_addr;
    case (r_burst)
      BURST_FIXED: w_next_addr = r_addr;
      BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
      default:     w_next_addr = w_addr_inc;
    endcase
    // First beat comes from the latched address; later beats from the advanced one.
    w_beat_addr = (r_rstate == R_DATA) ? w_next_addr : r_addr;
    w_beat_resp = RESP_OKAY;
    w_beat_data = '0;
    if (w_cfg_err) begin
      w_beat_resp = RESP_SLVERR;
    end else if (w_beat_addr[31:ADDR_W+2] != BASE[31:ADDR_W+2]) begin
      w_beat_resp = RESP_DECERR;
    end else begin
      w_beat_data = r_mem[w_beat_addr[ADDR_W+1:2]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_id      <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_addr    <= araddr;
            r_len     <= arlen;
            r_size    <= arsize;
            r_burst   <= arburst;
            r_id      <= arid;
            r_beat    <= '0;
            r_cnt     <= 8'(RD_LAT - 1);
            r_rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_beat_data;
            r_rresp  <= w_beat_resp;
            r_rlast  <= (r_len == 8'd0);
            r_rid    <= r_id;
            r_rstate <= R_DATA;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_rdata   <= '0;
              r_rresp   <= '0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_rdata <= w_beat_data;
              r_rresp <= w_beat_resp;
              r_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write side ----------------
  w_state_e    r_wstate;
  logic        r_awready, r_wready, r_aw_got, r_w_got;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0]  r_awid, r_wstrb;
  logic [7:0]  r_awlen;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;

  logic       w_aw_hs, w_w_hs, w_commit, w_aw_in_win, w_mem_we;
  logic [1:0] w_wr_resp;

  assign w_aw_hs     = awvalid && r_awready;
  assign w_w_hs      = wvalid && r_wready;
  assign w_commit    = (r_wstate == W_COLLECT) && r_aw_got && r_w_got;
  assign w_aw_in_win = (r_awaddr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign w_mem_we    = w_commit && (r_awlen == 8'd0) && w_aw_in_win;
  assign w_wr_resp   = (r_awlen != 8'd0) ? RESP_SLVERR :
                       (!w_aw_in_win)    ? RESP_DECERR : RESP_OKAY;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_awlen   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_bid     <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (w_aw_hs || w_w_hs) r_wstate <= W_COLLECT;
        end
        W_COLLECT: begin
          if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_resp;
            r_bid    <= r_awid;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_bid     <= '0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
      // Placed after the case so a handshake overrides the IDLE re-arm of the readies.
      if (w_aw_hs) begin
        r_awaddr  <= awaddr;
        r_awid    <= awid;
        r_awlen   <= awlen;
        r_aw_got  <= 1'b1;
        r_awready <= 1'b0;
      end
      // Non-last beats of an illegal burst are accepted and dropped.
      if (w_w_hs && wlast) begin
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
        r_w_got  <= 1'b1;
        r_wready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) r_mem[r_awaddr[ADDR_W+1:2]][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{awsize, awburst, r_awaddr[1:0], w_beat_addr[1:0]};

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign bid     = r_bid;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;
  assign rlast   = r_rlast;
  assign rid     = r_rid;

endmodule

// File: tb/tb_ysyx_23060236_axi_sram_slave.sv
// Directed + randomized bench for the AXI SRAM subordinate. A reference word array holds the
// first 64 words of the window; expected beat addresses and responses are derived
// arithmetically from the AXI burst rules.
module tb_ysyx_23060236_axi_sram_slave;

  localparam int unsigned ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          WORDS  = 64;

  logic        clock, reset;
  logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb, bid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        arready, arvalid, rready, rvalid, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [WORDS];

  ysyx_23060236_axi_sram_slave #(.ADDR_W(ADDR_W), .BASE(BASE), .RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 << ADDR_W));
  endfunction

  function automatic bit cfg_bad(input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'd2) || (len > 8'd15) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int n);
    longint bytes, total, s, lower;
    bytes = longint'(1) << size;
    total = (longint'(len) + 1) * bytes;
    s     = longint'(start);
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      lower = (s / total) * total;
      return 32'(lower + ((s - lower + longint'(n) * bytes) % total));
    end
    return 32'(s + longint'(n) * bytes);
  endfunction

  // Entered and left on a falling edge.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int n;
    logic [31:0] a, ed;
    logic [1:0]  er;
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clock); n++; end
    check("ar_accept", 32'(n < 20), 32'd1);
    @(negedge clock);
    arvalid = 1'b0;
    check("r_early", 32'(rvalid), 32'd0);
    @(negedge clock);
    check("r_latency", 32'(rvalid), 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      a = beat_addr(addr, len, size, burst, b);
      if (cfg_bad(len, size, burst)) begin er = 2'b10; ed = '0; end
      else if (!in_win(a))           begin er = 2'b11; ed = '0; end
      else begin er = 2'b00; ed = ref_mem[int'((a - BASE) >> 2)]; end
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clock); n++; end
      check("r_wait", 32'(n < 20), 32'd1);
      if (stall) begin
        rready = 1'b0;
        check("r_stall_data0", rdata, ed);
        @(negedge clock);
        check("r_stall_valid", 32'(rvalid), 32'd1);
        check("r_stall_data1", rdata, ed);
      end
      rready = 1'b1;
      check("r_data", rdata, ed);
      check("r_resp", 32'(rresp), 32'(er));
      check("r_last", 32'(rlast), 32'(b == int'(len)));
      check("r_id", 32'(rid), 32'(id));
      @(negedge clock);
      rready = 1'b0;
    end
    check("r_done_valid", 32'(rvalid), 32'd0);
    check("r_done_arready", 32'(arready), 32'd1);
  endtask

  // mode 0: AW and W together, 1: AW one cycle ahead of W, 2: W two cycles ahead of AW.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                          input logic [3:0] strb, input logic [7:0] len, input int mode);
    int aw_wait, w_wait, wsent, n;
    bit aw_done, hs_aw, hs_w;
    logic [1:0] eb;
    aw_wait = (mode == 2) ? 2 : 0;
    w_wait  = (mode == 1) ? 1 : 0;
    aw_done = 1'b0;
    wsent   = 0;
    for (int cyc = 0; cyc < 40 && !(aw_done && wsent > int'(len)); cyc++) begin
      awvalid = !aw_done && cyc >= aw_wait;
      awaddr = addr; awid = id; awlen = len; awsize = 3'd2; awburst = 2'b01;
      wvalid = (wsent <= int'(len)) && cyc >= w_wait;
      wdata = data; wstrb = strb; wlast = (wsent == int'(len));
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clock);
      if (hs_aw) aw_done = 1'b1;
      if (hs_w) wsent++;
    end
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    check("w_accept", 32'(aw_done && wsent == int'(len) + 1), 32'd1);
    eb = (len != 8'd0) ? 2'b10 : (!in_win(addr) ? 2'b11 : 2'b00);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clock); n++; end
    check("b_wait", 32'(n < 20), 32'd1);
    check("b_resp", 32'(bresp), 32'(eb));
    check("b_id", 32'(bid), 32'(id));
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    check("b_once", 32'(bvalid), 32'd0);
    if (eb == 2'b00) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) ref_mem[int'((addr - BASE) >> 2)][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  logic [7:0]  rl;
  logic [31:0] ra;
  int          kind, n0;

  initial begin
    clock = 1'b0; reset = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_arready", 32'(arready), 32'd1);

    for (int i = 0; i < WORDS; i++)
      do_write(BASE + 32'(4 * i), 4'(i), $urandom, 4'hF, 8'd0, i % 3);

    do_read(BASE + 32'h10, 4'h1, 8'd0, 3'd2, 2'b01, 1'b0);
    do_write(BASE + 32'h20, 4'h3, 32'hDEAD_BEEF, 4'b0101, 8'd0, 1);
    do_read(BASE + 32'h20, 4'h2, 8'd0, 3'd2, 2'b01, 1'b0);
    do_read(BASE + 32'h38, 4'h4, 8'd3, 3'd2, 2'b10, 1'b1);
    do_read(32'h7FFF_FFFC, 4'h5, 8'd1, 3'd2, 2'b01, 1'b0);
    do_write(BASE + 32'h24, 4'h7, $urandom, 4'hF, 8'd2, 0);
    do_read(BASE + 32'h24, 4'h6, 8'd0, 3'd2, 2'b01, 1'b0);
    do_write(BASE + 32'h28, 4'h8, $urandom, 4'h0, 8'd0, 2);
    do_write(BASE + 32'h4000, 4'h9, $urandom, 4'hF, 8'd0, 0);
    do_read(BASE + 32'h28, 4'hA, 8'd0, 3'd2, 2'b00, 1'b0);

    // Reset in the middle of a 4-beat burst.
    araddr = BASE + 32'h40; arid = 4'hB; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    n0 = 0;
    while (!arready && n0 < 20) begin @(negedge clock); n0++; end
    @(negedge clock);
    arvalid = 1'b0;
    n0 = 0;
    while (!rvalid && n0 < 20) begin @(negedge clock); n0++; end
    check("mid_rst_valid_before", 32'(rvalid), 32'd1);
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_rlast", 32'(rlast), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_release_arready", 32'(arready), 32'd1);
    do_read(BASE + 32'h10, 4'hC, 8'd0, 3'd2, 2'b01, 1'b0);

    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: do_write(BASE + 32'(4 * $urandom_range(0, WORDS - 1)), 4'($urandom), $urandom,
                    4'($urandom), 8'd0, int'($urandom_range(0, 2)));
        1: do_read(BASE + 32'(4 * $urandom_range(0, WORDS - 1)), 4'($urandom),
                   8'($urandom_range(0, 15)), 3'd2, 2'b00, 1'($urandom));
        2: begin
          rl = 8'($urandom_range(0, 15));
          do_read(BASE + 32'(4 * $urandom_range(0, WORDS - 1 - int'(rl))), 4'($urandom), rl,
                  3'd2, 2'b01, 1'($urandom));
        end
        3: begin
          ra = 32'(4 * $urandom_range(0, WORDS - 1));
          ra[31] = 1'b1;
          case ($urandom_range(0, 3))
            0: rl = 8'd1;
            1: rl = 8'd3;
            2: rl = 8'd7;
            default: rl = 8'd15;
          endcase
          do_read(ra, 4'($urandom), rl, 3'd2, 2'b10, 1'($urandom));
        end
        4: begin
          case ($urandom_range(0, 3))
            0: do_read(BASE, 4'h1, 8'd1, 3'd3, 2'b01, 1'b0);
            1: do_read(BASE + 32'h8, 4'h2, 8'd2, 3'd2, 2'b11, 1'b0);
            2: do_read(BASE + 32'h8, 4'h3, 8'd2, 3'd2, 2'b10, 1'b0);
            default: do_read(BASE, 4'h4, 8'd16, 3'd2, 2'b01, 1'b0);
          endcase
        end
        default: do_read(BASE - 32'(4 * $urandom_range(1, 4)), 4'($urandom), 8'd7, 3'd2,
                         2'b01, 1'($urandom));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
